// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 command router: opcodes, broadcast channel,
// FSM state encoding and status-word field offsets.
package md5_pkg;

   localparam logic [7:0] OP_LOAD  = 8'h01;
   localparam logic [7:0] OP_CLEAR = 8'h02;
   localparam logic [7:0] CH_ALL   = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COLLECT  = 2'd1,
      ST_DISPATCH = 2'd2
   } state_e;

   localparam int unsigned STAT_MATCH_LSB  = 0;
   localparam int unsigned STAT_LOADED_LSB = 8;
   localparam int unsigned STAT_ERR_LSB    = 16;
   localparam int unsigned STAT_STATE_LSB  = 24;

endpackage

// File: rtl/frame_shift_reg.sv
// Word-wide shift register assembling a frame; the first word shifted in ends
// up in the most significant word. The counter tracks words taken in the
// current frame; `full` means the next counted word completes the frame.
module frame_shift_reg #(
   parameter int unsigned WORD_W      = 32,
   parameter int unsigned FRAME_WORDS = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr,
   input  logic                          cnt_en,
   input  logic                          store_en,
   input  logic [WORD_W-1:0]             din,
   output logic [FRAME_WORDS*WORD_W-1:0] data,
   output logic                          full
);

   localparam int unsigned TD_W  = FRAME_WORDS * WORD_W;
   localparam int unsigned CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

   logic [TD_W-1:0]  data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign full = (cnt_q == CNT_W'(FRAME_WORDS - 1));
   assign data = data_q;

   // Next word count (wraps when the frame completes) and shifted frame data
   always_comb begin
      cnt_d  = cnt_q;
      data_d = data_q;
      if (clr) begin
         cnt_d = '0;
      end else if (cnt_en) begin
         cnt_d = full ? '0 : cnt_q + 1'b1;
      end
      if (store_en) begin
         data_d = (data_q << WORD_W) | TD_W'(din);
      end
   end

   // Frame and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         data_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/md5_cmd_router.sv
// Command router between the SPI word path and a bank of MD5 cores: parses
// LOAD/CLEAR headers, assembles target frames and dispatches them over a
// per-channel valid/ready handshake; keeps sticky match/loaded flags and a
// saturating error counter reported in status_word.
// Optional build macro MD5_ROUTER_TIMEOUT_EN: abort a frame after TIMEOUT_CYC
// idle cycles inside COLLECT.
module md5_cmd_router
   import md5_pkg::*;
#(
   parameter int unsigned WORD_W      = 32,
   parameter int unsigned FRAME_WORDS = 4,
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [WORD_W-1:0]             in_word,
   output logic [CHANNELS-1:0]           tgt_valid,
   input  logic [CHANNELS-1:0]           tgt_ready,
   output logic [FRAME_WORDS*WORD_W-1:0] tgt_data,
   input  logic [CHANNELS-1:0]           core_match,
   output logic [WORD_W-1:0]             status_word
);

   localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [7:0]  CH_LIM = 8'(CHANNELS);

   state_e              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic                discard_q, discard_d;
   logic [CHANNELS-1:0] tgt_valid_q, tgt_valid_d;
   logic [CHANNELS-1:0] match_q, match_d;
   logic [CHANNELS-1:0] loaded_q, loaded_d;
   logic [7:0]          err_q, err_d;
   logic [WORD_W-1:0]   status_q, status_d;

   logic [7:0]          opcode, hdr_ch;
   logic                hdr_in_range;
   logic [CHANNELS-1:0] ch_onehot, hdr_onehot, clr_mask, set_loaded;
   logic                err_inc;
   logic                fs_clr, fs_cnt_en, fs_store_en, fs_full;
   logic                to_hit;

   assign opcode       = in_word[31:24];
   assign hdr_ch       = in_word[7:0];
   assign hdr_in_range = (hdr_ch < CH_LIM);

   frame_shift_reg #(
      .WORD_W      (WORD_W),
      .FRAME_WORDS (FRAME_WORDS)
   ) u_frame (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (fs_clr),
      .cnt_en   (fs_cnt_en),
      .store_en (fs_store_en),
      .din      (in_word),
      .data     (tgt_data),
      .full     (fs_full)
   );

`ifdef MD5_ROUTER_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_q, to_d;

   // Idle-cycle counter: runs only in COLLECT, restarted by every word
   always_comb begin
      to_d   = '0;
      to_hit = 1'b0;
      if (state_q == ST_COLLECT && !in_valid) begin
         to_d   = to_q + 1'b1;
         to_hit = (to_d == TO_W'(TIMEOUT_CYC));
      end
   end

   // Idle-cycle counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) to_q <= '0;
      else        to_q <= to_d;
   end
`else
   localparam int unsigned UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
   assign to_hit = 1'b0;
`endif

   // FSM next state, flag updates, error counting and status packing
   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      discard_d   = discard_q;
      tgt_valid_d = tgt_valid_q;
      clr_mask    = '0;
      set_loaded  = '0;
      err_inc     = 1'b0;
      fs_clr      = 1'b0;
      fs_cnt_en   = 1'b0;
      fs_store_en = 1'b0;
      ch_onehot   = '0;
      ch_onehot[ch_q] = 1'b1;
      hdr_onehot  = '0;
      hdr_onehot[hdr_ch[CH_W-1:0]] = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               case (opcode)
                  OP_LOAD: begin
                     fs_clr    = 1'b1;
                     ch_d      = hdr_ch[CH_W-1:0];
                     discard_d = !hdr_in_range;
                     err_inc   = !hdr_in_range;
                     state_d   = ST_COLLECT;
                  end
                  OP_CLEAR: begin
                     if (hdr_ch == CH_ALL) clr_mask = '1;
                     else if (hdr_in_range) clr_mask = hdr_onehot;
                     else err_inc = 1'b1;
                  end
                  default: err_inc = 1'b1;
               endcase
            end
         end
         ST_COLLECT: begin
            if (in_valid) begin
               fs_cnt_en   = 1'b1;
               fs_store_en = !discard_q;
               if (fs_full) begin
                  if (discard_q) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d     = ST_DISPATCH;
                     tgt_valid_d = ch_onehot;
                  end
               end
            end else if (to_hit) begin
               state_d = ST_IDLE;
               err_inc = 1'b1;
            end
         end
         ST_DISPATCH: begin
            if (in_valid) err_inc = 1'b1;
            if (|(tgt_valid_q & tgt_ready & ch_onehot)) begin
               tgt_valid_d = '0;
               set_loaded  = ch_onehot;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A match arriving alongside a CLEAR survives it
      match_d  = (match_q & ~clr_mask) | core_match;
      loaded_d = (loaded_q & ~clr_mask) | set_loaded;
      err_d    = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

      status_d = '0;
      status_d[STAT_MATCH_LSB  +: CHANNELS] = match_d;
      status_d[STAT_LOADED_LSB +: CHANNELS] = loaded_d;
      status_d[STAT_ERR_LSB    +: 8]        = err_d;
      status_d[STAT_STATE_LSB  +: 2]        = state_d;
   end

   // State, flag, counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ch_q        <= '0;
         discard_q   <= 1'b0;
         tgt_valid_q <= '0;
         match_q     <= '0;
         loaded_q    <= '0;
         err_q       <= '0;
         status_q    <= '0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         discard_q   <= discard_d;
         tgt_valid_q <= tgt_valid_d;
         match_q     <= match_d;
         loaded_q    <= loaded_d;
         err_q       <= err_d;
         status_q    <= status_d;
      end
   end

   assign tgt_valid   = tgt_valid_q;
   assign status_word = status_q;

endmodule

// File: tb/tb_md5_cmd_router.sv
// Self-checking bench for md5_cmd_router: a table of header/payload vectors
// with expected status, a dispatch scoreboard, and hand-written sequences for
// back-pressure, sticky match flags, timeout/idle COLLECT and mid-frame reset.
module tb_md5_cmd_router;
   import md5_pkg::*;

   localparam int unsigned WW = 32;
   localparam int unsigned FW = 4;
   localparam int unsigned CH = 4;
`ifdef MD5_ROUTER_TIMEOUT_EN
   localparam int unsigned TO_CYC = 16;
`else
   localparam int unsigned TO_CYC = 1_000_000;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic [WW-1:0]    in_word = '0;
   logic [CH-1:0]    tgt_valid;
   logic [CH-1:0]    tgt_ready = '1;
   logic [FW*WW-1:0] tgt_data;
   logic [CH-1:0]    core_match = '0;
   logic [WW-1:0]    status_word;

   always #5 clk = ~clk;

   md5_cmd_router #(
      .WORD_W      (WW),
      .FRAME_WORDS (FW),
      .CHANNELS    (CH),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_word     (in_word),
      .tgt_valid   (tgt_valid),
      .tgt_ready   (tgt_ready),
      .tgt_data    (tgt_data),
      .core_match  (core_match),
      .status_word (status_word)
   );

   typedef struct {
      logic [CH-1:0]    onehot;
      logic [FW*WW-1:0] data;
   } exp_t;

   typedef struct {
      logic [7:0]       op;
      logic [7:0]       ch;
      logic [FW*WW-1:0] payload;
      int unsigned      exp_vcyc;
      logic [3:0]       exp_loaded;
      logic [7:0]       exp_err;
   } vec_t;

   exp_t        sb_q[$];
   int unsigned n_tests = 0;
   int unsigned n_fail = 0;
   int unsigned valid_cyc = 0;
   int unsigned stall_cyc = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Dispatch monitor, sampled on the falling edge
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && tgt_valid != '0) begin
         valid_cyc++;
         if ((tgt_valid & tgt_ready) == '0) begin
            stall_cyc++;
         end else if (sb_q.size() == 0) begin
            check("unexpected_dispatch", 128'(tgt_valid), 128'(0));
         end else begin
            e = sb_q.pop_front();
            check("dispatch_valid", 128'(tgt_valid), 128'(e.onehot));
            check("dispatch_data", tgt_data, e.data);
         end
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input logic [WW-1:0] w);
      in_valid = 1'b1;
      in_word  = w;
      tick(1);
      in_valid = 1'b0;
      in_word  = '0;
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [7:0] ch, input logic [FW*WW-1:0] p);
      exp_t e;
      if (op == OP_LOAD && ch < CH) begin
         e.onehot = '0;
         e.onehot[ch[1:0]] = 1'b1;
         e.data = p;
         sb_q.push_back(e);
      end
      send_word({op, 16'h5A00, ch});
      if (op == OP_LOAD) begin
         for (int unsigned i = 0; i < FW; i++) send_word(p[FW*WW-1-WW*i -: WW]);
      end
   endtask

   task automatic wait_idle(input string name);
      int unsigned n = 0;
      while ((status_word[25:24] != 2'd0 || tgt_valid != '0) && n < 200) begin
         tick(1);
         n++;
      end
      if (n >= 200) check({name, "_idle_budget"}, 128'(status_word[25:24]), 128'(0));
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      sb_q.delete();
      valid_cyc = 0;
      stall_cyc = 0;
   endtask

   vec_t vecs[10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{OP_LOAD,  8'd1,   128'h11111111_22222222_33333333_44444444, 1, 4'b0010, 8'd0};
      vecs[1] = '{OP_LOAD,  8'd0,   128'hA5A5A5A5_0F0F0F0F_DEADBEEF_00000001, 1, 4'b0011, 8'd0};
      vecs[2] = '{OP_LOAD,  8'd5,   128'hCAFEBABE_12345678_9ABCDEF0_FFFFFFFF, 0, 4'b0011, 8'd1};
      vecs[3] = '{OP_LOAD,  8'd0,   128'h01234567_89ABCDEF_FEDCBA98_76543210, 1, 4'b0011, 8'd1};
      vecs[4] = '{OP_CLEAR, 8'd1,   128'h0, 0, 4'b0001, 8'd1};
      vecs[5] = '{8'h7E,    8'd0,   128'h0, 0, 4'b0001, 8'd2};
      vecs[6] = '{OP_CLEAR, 8'd9,   128'h0, 0, 4'b0001, 8'd3};
      vecs[7] = '{OP_LOAD,  8'd3,   128'h80000000_00000000_00000000_00000003, 1, 4'b1001, 8'd3};
      vecs[8] = '{OP_CLEAR, CH_ALL, 128'h0, 0, 4'b0000, 8'd3};
      vecs[9] = '{OP_LOAD,  8'd2,   128'hFFFFFFFF_00000000_FFFFFFFF_13579BDF, 1, 4'b0100, 8'd3};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_tgt_valid", 128'(tgt_valid), 128'(0));
      check("rst_tgt_data", tgt_data, 128'(0));
      check("rst_status", 128'(status_word), 128'(0));
      rst_n = 1'b1;
      tick(1);

      // Table-driven vectors, applied back to back
      for (int i = 0; i < 10; i++) begin
         valid_cyc = 0;
         send_frame(vecs[i].op, vecs[i].ch, vecs[i].payload);
         wait_idle($sformatf("v%0d", i));
         tick(1);
         check($sformatf("v%0d_loaded", i), 128'(status_word[11:8]), 128'(vecs[i].exp_loaded));
         check($sformatf("v%0d_err", i), 128'(status_word[23:16]), 128'(vecs[i].exp_err));
         check($sformatf("v%0d_vcyc", i), 128'(valid_cyc), 128'(vecs[i].exp_vcyc));
         check($sformatf("v%0d_sb_empty", i), 128'(sb_q.size()), 128'(0));
         check($sformatf("v%0d_rsvd", i),
               128'({status_word[31:26], status_word[15:12], status_word[7:4]}), 128'(0));
      end

      // Back-pressure on ch2 for 10 cycles with a stray word in DISPATCH
      reset_dut();
      tgt_ready = 4'b1011;
      send_frame(OP_LOAD, 8'd2, 128'h0BADF00D_11223344_55667788_99AABBCC);
      tick(4);
      check("bp_state_dispatch", 128'(status_word[25:24]), 128'(2));
      check("bp_valid_held", 128'(tgt_valid), 128'(4'b0100));
      send_word(32'h01000001);
      tick(5);
      tgt_ready = 4'b1111;
      wait_idle("bp");
      check("bp_stall_cycles", 128'(stall_cyc), 128'(10));
      check("bp_valid_cycles", 128'(valid_cyc), 128'(11));
      check("bp_err", 128'(status_word[23:16]), 128'(1));
      check("bp_loaded", 128'(status_word[11:8]), 128'(4'b0100));
      check("bp_sb_empty", 128'(sb_q.size()), 128'(0));

      // Sticky match, CLEAR all, and set-beats-clear in the same cycle
      reset_dut();
      core_match = 4'b1000;
      tick(1);
      core_match = 4'b0000;
      check("match_latency", 128'(status_word[3:0]), 128'(4'b1000));
      tick(5);
      check("match_sticky", 128'(status_word[3:0]), 128'(4'b1000));
      send_frame(OP_LOAD, 8'd1, 128'h00000001_00000002_00000003_00000004);
      wait_idle("match_load");
      check("match_loaded", 128'(status_word[11:8]), 128'(4'b0010));
      core_match = 4'b0001;
      send_word({OP_CLEAR, 16'h0000, CH_ALL});
      core_match = 4'b0000;
      check("clr_all_match", 128'(status_word[3:0]), 128'(4'b0001));
      check("clr_all_loaded", 128'(status_word[11:8]), 128'(0));
      tick(2);
      check("set_wins_sticky", 128'(status_word[3:0]), 128'(4'b0001));

      // Stalled frame: timeout abort, or indefinite wait without the timer
      reset_dut();
      send_word({OP_LOAD, 16'h0000, 8'd0});
      send_word(32'hAAAA0001);
      send_word(32'hAAAA0002);
      tick(20);
`ifdef MD5_ROUTER_TIMEOUT_EN
      check("to_state_idle", 128'(status_word[25:24]), 128'(0));
      check("to_err", 128'(status_word[23:16]), 128'(1));
      send_frame(OP_LOAD, 8'd0, 128'h10101010_20202020_30303030_40404040);
      wait_idle("to_after");
      check("to_after_loaded", 128'(status_word[11:8]), 128'(4'b0001));
`else
      check("wait_state_collect", 128'(status_word[25:24]), 128'(1));
      check("wait_err", 128'(status_word[23:16]), 128'(0));
      sb_q.push_back('{4'b0001, 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004});
      send_word(32'hAAAA0003);
      send_word(32'hAAAA0004);
      wait_idle("wait_after");
      check("wait_after_loaded", 128'(status_word[11:8]), 128'(4'b0001));
`endif
      check("stall_sb_empty", 128'(sb_q.size()), 128'(0));

      // Asynchronous reset in the middle of COLLECT
      reset_dut();
      send_word({OP_LOAD, 16'h0000, 8'd3});
      send_word(32'h12345678);
      send_word(32'h9ABCDEF0);
      check("mid_state_collect", 128'(status_word[25:24]), 128'(1));
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 128'(tgt_valid), 128'(0));
      check("mid_rst_data", tgt_data, 128'(0));
      check("mid_rst_status", 128'(status_word), 128'(0));
      tick(2);
      rst_n = 1'b1;
      tick(1);
      valid_cyc = 0;
      send_frame(OP_LOAD, 8'd3, 128'hFEEDFACE_C0FFEE00_BEEFCAFE_0DDBA11E);
      wait_idle("mid_after");
      check("mid_after_loaded", 128'(status_word[11:8]), 128'(4'b1000));
      check("mid_after_err", 128'(status_word[23:16]), 128'(0));
      check("mid_after_vcyc", 128'(valid_cyc), 128'(1));
      check("final_sb_empty", 128'(sb_q.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/md5_cmd_router.md
# md5_cmd_router

Single-clock command router between the SPI word path (after the cross-domain buffer) and a bank of MD5 brute-force cores. Parses a header word, assembles `FRAME_WORDS` payload words into a wide target frame, and dispatches it to one of `CHANNELS` cores over a valid/ready handshake. Maintains latched per-channel match/loaded flags and an error counter, packed into a status word returned on MISO.

## Interface
- `WORD_W`, 32, SPI word width; ≥ 32.
- `FRAME_WORDS`, 4, payload words per LOAD frame; 128-bit digest at default.
- `CHANNELS`, 4, number of cores; 1..8.
- `TIMEOUT_CYC`, 1_000_000, max idle cycles between words inside a frame.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: one-cycle pulse, `in_word` valid.
- `in_word` in WORD_W: received SPI word.
- `tgt_valid` out CHANNELS: per-channel frame offer.
- `tgt_ready` in CHANNELS: per-channel accept.
- `tgt_data` out FRAME_WORDS*WORD_W: assembled frame, shared by all channels.
- `core_match` in CHANNELS: level from each core, sampled every cycle.
- `status_word` out WORD_W: packed status.

## Operation
- Header word: opcode `in_word[31:24]`, channel `in_word[7:0]`.
  - Opcode 0x01 is LOAD.
  - Opcode 0x02 is CLEAR.
  - Any other opcode is an error.
- States: IDLE, COLLECT, DISPATCH.
- IDLE, LOAD header with channel < CHANNELS:
  - Latch the channel, clear the word counter, go to COLLECT.
- IDLE, LOAD header with channel ≥ CHANNELS:
  - Go to COLLECT with the discard flag set.
  - Payload is consumed but not stored; error counter +1.
- IDLE, CLEAR header:
  - Clear `match_latched[ch]` and `loaded[ch]`. Channel 0xFF clears all channels.
  - Other out-of-range channels: error +1.
  - Stay in IDLE.
- IDLE, unknown opcode: error +1, stay in IDLE.
- COLLECT:
  - Each word shifts into the frame; the first payload word lands in the MS word.
  - When the counter reaches FRAME_WORDS, go to DISPATCH, or to IDLE if the discard flag is set.
- DISPATCH:
  - Hold `tgt_valid[ch]`=1 until `tgt_ready[ch]`.
  - On the handshake, set `loaded[ch]` and return to IDLE.
  - `in_word` arriving in DISPATCH is dropped; error +1.
- `match_latched[i]` is set when `core_match[i]`=1. It stays sticky until CLEAR.
  - If set and CLEAR occur in the same cycle, the set wins.
- Error counter: 8 bits, saturates at 255. It is cleared only by reset.
- `status_word` layout:
  - [CHANNELS-1:0] = `match_latched`
  - [8+:CHANNELS] = `loaded`
  - [23:16] = error count
  - [25:24] = state (0 IDLE, 1 COLLECT, 2 DISPATCH)
  - All other bits are 0.
- Reset values:
  - `tgt_valid` = 0, `tgt_data` = 0, `status_word` = 0.
  - All flags and counters 0, state IDLE.
- Asserting reset mid-frame aborts the frame, with no dispatch.

## Timing
- All outputs are registered.
- `tgt_valid` rises the cycle after the clock edge that accepts the last payload word.
- `tgt_data` is stable from that cycle until the handshake completes.
- Handshake completes on the edge where `tgt_valid[ch]` & `tgt_ready[ch]` are both 1. `tgt_valid` is 0 on the next cycle.
- IDLE accepts a new header on the cycle after the handshake.
- `status_word` reflects any event one cycle after it.
- `core_match` to `match_latched` latency is 1 cycle.
- Back-to-back `in_valid` on consecutive cycles is legal.

## Configuration
- `MD5_ROUTER_TIMEOUT_EN` defined:
  - A counter runs while in COLLECT and is reset by each `in_valid`.
  - When it reaches TIMEOUT_CYC: abort to IDLE, discard the partial frame, error +1.
- Not defined: no counter exists; COLLECT waits indefinitely.

## Structure
- Shared package `md5_pkg`:
  - Opcode constants `OP_LOAD`, `OP_CLEAR`.
  - `CH_ALL` = 8'hFF.
  - State encoding and the status-field bit offsets.
- One sub-module, `frame_shift_reg`: parametrised WORD_W×FRAME_WORDS shift register with a word counter and a `full` flag.
- FSM, flags and counters live in the top module.

## Test plan
- LOAD ch1 with words 0x11111111..0x44444444, `tgt_ready[1]` tied 1:
  - `tgt_valid`=4'b0010 for 1 cycle.
  - `tgt_data`=0x11111111_22222222_33333333_44444444.
  - `status_word[9]`=1.
- LOAD ch2 with `tgt_ready` held 0 for 10 cycles, one extra `in_word` sent meanwhile:
  - `tgt_valid[2]` held for 10 cycles.
  - Error count = 1.
  - Handshake completes on the first `ready`.
- LOAD with ch 5 (CHANNELS=4) plus 4 payload words, then a valid LOAD ch0:
  - No `tgt_valid` for the bad frame; error = 1.
  - The ch0 frame dispatches correctly.
- Pulse `core_match[3]` for 1 cycle:
  - `status_word[3]`=1 persists.
  - CLEAR 0xFF returns bits [3] and [11:8] to 0.
- `MD5_ROUTER_TIMEOUT_EN`, TIMEOUT_CYC=16: LOAD header, 2 words, then 20 idle cycles:
  - State returns to IDLE; error = 1.
  - A subsequent full frame dispatches.
- Deassert `rst_n` mid-COLLECT:
  - All outputs go to 0 immediately (asynchronously).
  - After release, a full LOAD dispatches normally.
